// File: rtl/issue_pkg.sv
// Shared definitions for the dual-issue scheduler.
//   - Issue-select encodings driven on issue_sel_inst1/inst2.
//   - Scheduler state encoding.
//   - Bit positions inside the 4-bit {regwrite, memread, memwrite, branch} ctrl field.
package issue_pkg;

    localparam logic [1:0] SEL_BUBBLE = 2'b00;
    localparam logic [1:0] SEL_A      = 2'b01;
    localparam logic [1:0] SEL_B      = 2'b10;

    typedef enum logic {
        S_BOTH   = 1'b0,  // A and B both pending
        S_B_ONLY = 1'b1   // A already issued, B still pending
    } state_e;

    localparam int unsigned CTRL_REGWRITE = 3;
    localparam int unsigned CTRL_MEMREAD  = 2;
    localparam int unsigned CTRL_MEMWRITE = 1;
    localparam int unsigned CTRL_BRANCH   = 0;

endpackage

// File: rtl/issue_hazard_check.sv
// Load-use hazard check for one decoded instruction against the two EX slots.
// Ports:
//   rs_i, rt_i             source register specifiers of the instruction
//   ex_rd1_i, ex_rd2_i     destination registers of EX inst1/inst2
//   ex_memread1_i/2_i      EX inst1/inst2 is a load
//   luh_o                  instruction must wait for a load still in EX
module issue_hazard_check #(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic [REG_W-1:0] ex_rd1_i,
    input  logic [REG_W-1:0] ex_rd2_i,
    input  logic             ex_memread1_i,
    input  logic             ex_memread2_i,
    output logic             luh_o
);

    logic rs_hit;
    logic rt_hit;

    // r0 is hardwired zero, so it can never depend on a load.
    assign rs_hit = (rs_i != '0) &&
                    ((ex_memread1_i && (rs_i == ex_rd1_i)) ||
                     (ex_memread2_i && (rs_i == ex_rd2_i)));
    assign rt_hit = (rt_i != '0) &&
                    ((ex_memread1_i && (rt_i == ex_rd1_i)) ||
                     (ex_memread2_i && (rt_i == ex_rd2_i)));

    assign luh_o = rs_hit || rt_hit;

endmodule

// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: picks which of the decoded pair (A older, B younger)
// enters ID/EX slots inst1/inst2 each cycle. The older issued instruction is
// always placed in inst1 so that forwarding's inst2 priority stays correct.
// Optional feature macro: ISSUE_PERF_CNT_EN (adds cnt_dual/cnt_single/cnt_stall).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   pair_valid, b_valid             pair present / slot B holds an instruction
//   a_rs/a_rt/a_rd/a_ctrl           fields of A (ctrl = {regwrite,memread,memwrite,branch})
//   b_rs/b_rt/b_rd/b_ctrl           fields of B
//   ex_rd_inst1/2, ex_memread_inst1/2  EX-stage destination / load flags
//   flush                           branch redirect, drop pending pair
//   issue_sel_inst1/2               00 bubble, 01 A, 10 B
//   pair_ready                      pair fully consumed this cycle
//   stall                           nothing issued while pair_valid=1
module dual_issue_scheduler
    import issue_pkg::*;
#(
    parameter int unsigned REG_W = 5
`ifdef ISSUE_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ISSUE_PERF_CNT_EN
    output logic [CNT_W-1:0] cnt_dual,
    output logic [CNT_W-1:0] cnt_single,
    output logic [CNT_W-1:0] cnt_stall,
`endif
    input  logic             pair_valid,
    input  logic             b_valid,
    input  logic [REG_W-1:0] a_rs,
    input  logic [REG_W-1:0] a_rt,
    input  logic [REG_W-1:0] a_rd,
    input  logic [3:0]       a_ctrl,
    input  logic [REG_W-1:0] b_rs,
    input  logic [REG_W-1:0] b_rt,
    input  logic [REG_W-1:0] b_rd,
    input  logic [3:0]       b_ctrl,
    input  logic [REG_W-1:0] ex_rd_inst1,
    input  logic [REG_W-1:0] ex_rd_inst2,
    input  logic             ex_memread_inst1,
    input  logic             ex_memread_inst2,
    input  logic             flush,
    output logic [1:0]       issue_sel_inst1,
    output logic [1:0]       issue_sel_inst2,
    output logic             pair_ready,
    output logic             stall
);

    state_e     state_q, state_d;
    logic       luh_a, luh_b;
    logic       raw_ab, mem_both, split;
    logic [1:0] sel1, sel2;
    logic       ready, stall_c;

    issue_hazard_check #(.REG_W(REG_W)) u_hz_a (
        .rs_i          (a_rs),
        .rt_i          (a_rt),
        .ex_rd1_i      (ex_rd_inst1),
        .ex_rd2_i      (ex_rd_inst2),
        .ex_memread1_i (ex_memread_inst1),
        .ex_memread2_i (ex_memread_inst2),
        .luh_o         (luh_a)
    );

    issue_hazard_check #(.REG_W(REG_W)) u_hz_b (
        .rs_i          (b_rs),
        .rt_i          (b_rt),
        .ex_rd1_i      (ex_rd_inst1),
        .ex_rd2_i      (ex_rd_inst2),
        .ex_memread1_i (ex_memread_inst1),
        .ex_memread2_i (ex_memread_inst2),
        .luh_o         (luh_b)
    );

    // B's destination and B's own regwrite/branch never affect pairing
    // (WAW is resolved by inst2 forwarding priority).
    logic unused_b;
    assign unused_b = ^{b_rd, b_ctrl[CTRL_REGWRITE], b_ctrl[CTRL_BRANCH]};

    assign raw_ab   = a_ctrl[CTRL_REGWRITE] && (a_rd != '0) &&
                      ((b_rs == a_rd) || (b_rt == a_rd));
    assign mem_both = (a_ctrl[CTRL_MEMREAD] || a_ctrl[CTRL_MEMWRITE]) &&
                      (b_ctrl[CTRL_MEMREAD] || b_ctrl[CTRL_MEMWRITE]);
    assign split    = raw_ab || mem_both || a_ctrl[CTRL_BRANCH];

    always_comb begin
        state_d = state_q;
        sel1    = SEL_BUBBLE;
        sel2    = SEL_BUBBLE;
        ready   = 1'b0;
        stall_c = 1'b0;
        if (flush) begin
            state_d = S_BOTH;
        end else if (pair_valid) begin
            unique case (state_q)
                S_BOTH: begin
                    if (luh_a) begin
                        stall_c = 1'b1;
                    end else if (!b_valid) begin
                        sel1  = SEL_A;
                        ready = 1'b1;
                    end else if (split || luh_b) begin
                        sel1    = SEL_A;
                        state_d = S_B_ONLY;
                    end else begin
                        sel1  = SEL_A;
                        sel2  = SEL_B;
                        ready = 1'b1;
                    end
                end
                S_B_ONLY: begin
                    if (luh_b) begin
                        stall_c = 1'b1;
                    end else begin
                        sel1    = SEL_B;
                        ready   = 1'b1;
                        state_d = S_BOTH;
                    end
                end
                default: state_d = S_BOTH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOTH;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are forced low for the whole time reset is held.
    assign issue_sel_inst1 = rst_n ? sel1    : SEL_BUBBLE;
    assign issue_sel_inst2 = rst_n ? sel2    : SEL_BUBBLE;
    assign pair_ready      = rst_n ? ready   : 1'b0;
    assign stall           = rst_n ? stall_c : 1'b0;

`ifdef ISSUE_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_dual_q, cnt_single_q, cnt_stall_q;
    logic             is_dual, is_single;

    assign is_dual   = (sel1 != SEL_BUBBLE) && (sel2 != SEL_BUBBLE);
    assign is_single = (sel1 != SEL_BUBBLE) && (sel2 == SEL_BUBBLE);

    // Flush cycles produce no issue and no stall, so they are never counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_dual_q   <= '0;
            cnt_single_q <= '0;
            cnt_stall_q  <= '0;
        end else begin
            if (is_dual)   cnt_dual_q   <= cnt_dual_q + 1'b1;
            if (is_single) cnt_single_q <= cnt_single_q + 1'b1;
            if (stall_c)   cnt_stall_q  <= cnt_stall_q + 1'b1;
        end
    end

    assign cnt_dual   = cnt_dual_q;
    assign cnt_single = cnt_single_q;
    assign cnt_stall  = cnt_stall_q;
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
module tb_dual_issue_scheduler;

    localparam int REG_W = 5;
    localparam logic [3:0] ALU = 4'b1000;  // regwrite only
    localparam logic [3:0] LW  = 4'b1100;
    localparam logic [3:0] SW  = 4'b0010;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pair_valid, b_valid, flush;
    logic [REG_W-1:0] a_rs, a_rt, a_rd, b_rs, b_rt, b_rd;
    logic [3:0]       a_ctrl, b_ctrl;
    logic [REG_W-1:0] ex_rd_inst1, ex_rd_inst2;
    logic             ex_memread_inst1, ex_memread_inst2;
    logic [1:0]       issue_sel_inst1, issue_sel_inst2;
    logic             pair_ready, stall;
`ifdef ISSUE_PERF_CNT_EN
    logic [31:0]      cnt_dual, cnt_single, cnt_stall;
`endif

    int errors = 0;
    int checks = 0;
    bit m_b_pending = 1'b0;  // model: A of current pair already issued

    always #5 clk = ~clk;

    dual_issue_scheduler #(.REG_W(REG_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
`ifdef ISSUE_PERF_CNT_EN
        .cnt_dual         (cnt_dual),
        .cnt_single       (cnt_single),
        .cnt_stall        (cnt_stall),
`endif
        .pair_valid       (pair_valid),
        .b_valid          (b_valid),
        .a_rs             (a_rs),
        .a_rt             (a_rt),
        .a_rd             (a_rd),
        .a_ctrl           (a_ctrl),
        .b_rs             (b_rs),
        .b_rt             (b_rt),
        .b_rd             (b_rd),
        .b_ctrl           (b_ctrl),
        .ex_rd_inst1      (ex_rd_inst1),
        .ex_rd_inst2      (ex_rd_inst2),
        .ex_memread_inst1 (ex_memread_inst1),
        .ex_memread_inst2 (ex_memread_inst2),
        .flush            (flush),
        .issue_sel_inst1  (issue_sel_inst1),
        .issue_sel_inst2  (issue_sel_inst2),
        .pair_ready       (pair_ready),
        .stall            (stall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit reads_loaded(input logic [REG_W-1:0] r);
        if (r == 0) return 1'b0;
        return (ex_memread_inst1 && r == ex_rd_inst1) || (ex_memread_inst2 && r == ex_rd_inst2);
    endfunction

    function automatic bit is_mem(input logic [3:0] c);
        return c[2] | c[1];
    endfunction

    // Evaluate the reference decision, compare, then advance one clock.
    task automatic step(input string tag);
        logic [1:0] e1, e2;
        bit er, es, nb, must_split, wait_a, wait_b;
        e1 = 2'b00; e2 = 2'b00; er = 1'b0; es = 1'b0;
        if (!rst_n) m_b_pending = 1'b0;
        nb = m_b_pending;
        wait_a = reads_loaded(a_rs) || reads_loaded(a_rt);
        wait_b = reads_loaded(b_rs) || reads_loaded(b_rt);
        must_split = (a_ctrl[3] && a_rd != 0 && (b_rs == a_rd || b_rt == a_rd)) ||
                     (is_mem(a_ctrl) && is_mem(b_ctrl)) || a_ctrl[0];
        if (!rst_n) begin
            nb = 1'b0;
        end else if (flush) begin
            nb = 1'b0;
        end else if (!pair_valid) begin
            nb = m_b_pending;
        end else if (m_b_pending) begin
            if (wait_b) es = 1'b1;
            else begin e1 = 2'b10; er = 1'b1; nb = 1'b0; end
        end else if (wait_a) begin
            es = 1'b1;
        end else if (!b_valid) begin
            e1 = 2'b01; er = 1'b1;
        end else if (must_split || wait_b) begin
            e1 = 2'b01; nb = 1'b1;
        end else begin
            e1 = 2'b01; e2 = 2'b10; er = 1'b1;
        end
        #1;
        chk({tag, ".sel1"},  32'(issue_sel_inst1), 32'(e1));
        chk({tag, ".sel2"},  32'(issue_sel_inst2), 32'(e2));
        chk({tag, ".ready"}, 32'(pair_ready),      32'(er));
        chk({tag, ".stall"}, 32'(stall),           32'(es));
        @(posedge clk);
        m_b_pending = rst_n ? nb : 1'b0;
        @(negedge clk);
    endtask

    task automatic set_pair(input logic [REG_W-1:0] ars, art, ard, input logic [3:0] actl,
                            input logic [REG_W-1:0] brs, brt, brd, input logic [3:0] bctl,
                            input logic bv);
        a_rs = ars; a_rt = art; a_rd = ard; a_ctrl = actl;
        b_rs = brs; b_rt = brt; b_rd = brd; b_ctrl = bctl; b_valid = bv;
    endtask

    task automatic set_ex(input logic [REG_W-1:0] rd1, input logic m1,
                          input logic [REG_W-1:0] rd2, input logic m2);
        ex_rd_inst1 = rd1; ex_memread_inst1 = m1; ex_rd_inst2 = rd2; ex_memread_inst2 = m2;
    endtask

    initial begin
        rst_n = 1'b0; pair_valid = 1'b0; flush = 1'b0;
        set_pair(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 1'b0);
        set_ex(0, 1'b0, 0, 1'b0);
        @(negedge clk);
        pair_valid = 1'b1;
        set_pair(1, 2, 3, ALU, 4, 5, 6, ALU, 1'b1);
        step("reset");
        rst_n = 1'b1;

        step("indep");
        set_pair(1, 2, 3, ALU, 3, 5, 6, ALU, 1'b1);
        step("raw_c0");
        step("raw_c1");
        set_pair(7, 2, 3, ALU, 4, 5, 6, ALU, 1'b1);
        set_ex(0, 1'b0, 7, 1'b1);
        step("luh_stall");
`ifdef ISSUE_PERF_CNT_EN
        chk("cnt_dual",   cnt_dual,   32'd1);
        chk("cnt_single", cnt_single, 32'd2);
        chk("cnt_stall",  cnt_stall,  32'd1);
`endif
        set_ex(0, 1'b0, 0, 1'b0);
        step("luh_clear");

        set_pair(1, 0, 8, LW, 2, 9, 0, SW, 1'b1);
        step("lwsw_c0");
        step("lwsw_c1");
        set_pair(1, 0, 8, LW, 0, 0, 0, 4'h0, 1'b0);
        step("lone_lw");

        set_pair(1, 2, 3, ALU, 3, 5, 6, ALU, 1'b1);
        step("fl_split");
        flush = 1'b1;
        step("flush");
        flush = 1'b0;
        set_pair(1, 2, 3, ALU, 4, 5, 6, ALU, 1'b1);
        step("after_flush");

        pair_valid = 1'b0;
        step("no_pair");
        pair_valid = 1'b1;
        set_pair(1, 2, 0, ALU, 0, 5, 6, ALU, 1'b1);
        set_ex(0, 1'b1, 0, 1'b1);
        step("reg0");
        set_ex(0, 1'b0, 0, 1'b0);

        set_pair(1, 2, 3, ALU, 4, 5, 6, ALU, 1'b1);
        set_ex(5, 1'b1, 0, 1'b0);
        step("luh_b_split");
        step("luh_b_hold");
        set_ex(0, 1'b0, 0, 1'b0);
        step("luh_b_go");

        set_pair(1, 2, 3, ALU, 3, 5, 6, ALU, 1'b1);
        step("rst_split");
        rst_n = 1'b0;
        step("mid_reset");
        rst_n = 1'b1;
        set_pair(1, 2, 3, ALU, 4, 5, 6, ALU, 1'b1);
        step("after_reset");

        for (int i = 0; i < 400; i++) begin
            if (!m_b_pending) begin
                set_pair(REG_W'($urandom_range(0, 7)), REG_W'($urandom_range(0, 7)),
                         REG_W'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                         REG_W'($urandom_range(0, 7)), REG_W'($urandom_range(0, 7)),
                         REG_W'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                         1'($urandom_range(0, 4) != 0));
            end
            set_ex(REG_W'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0),
                   REG_W'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0));
            pair_valid = ($urandom_range(0, 9) != 0);
            flush      = ($urandom_range(0, 19) == 0);
            rst_n      = ($urandom_range(0, 99) != 0);
            step("rnd");
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
